// File: rtl/neuron_pkg.sv
// Shared types and arithmetic helpers for the neuron multiply-accumulate block.
package neuron_pkg;

  // Evaluation phases: collect elements, let the pipeline empty, present result.
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Width used for the final bias-add / shift / saturate arithmetic. It must be
  // at least one bit wider than the accumulator so the bias add cannot wrap.
  localparam int unsigned CALC_W = 64;

  // Arithmetic right shift (floor) by frac_width, then clamp to a signed
  // data_width range. The caller keeps the low data_width bits.
  function automatic logic signed [CALC_W-1:0] shift_sat(
    input logic signed [CALC_W-1:0] value,
    input int unsigned              frac_width,
    input int unsigned              data_width
  );
    logic signed [CALC_W-1:0] shifted;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    shifted = value >>> frac_width;
    max_v   = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    if (shifted > max_v) begin
      shift_sat = max_v;
    end else if (shifted < min_v) begin
      shift_sat = min_v;
    end else begin
      shift_sat = shifted;
    end
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Single neuron evaluation: streams numWeight signed fixed-point inputs,
// multiplies each by a weight fetched from an external synchronous memory,
// accumulates, then adds bias, rescales and saturates into out_data.
// Latency from the last accepted element to out_valid is three edges:
// input register -> product register -> accumulator -> output register.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracWidth    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [dataWidth-1:0] in_data,
  output logic                        in_ready,
  output logic                        w_rd_en,
  output logic [addressWidth-1:0]     w_rd_addr,
  input  logic signed [dataWidth-1:0] w_rd_data,
  input  logic signed [dataWidth-1:0] bias,
  output logic                        out_valid,
  output logic signed [dataWidth-1:0] out_data,
  input  logic                        out_ready
);

  localparam int PROD_W = 2 * dataWidth;
  // One guard bit per doubling of the term count plus one: the sum of
  // numWeight full-range products can never overflow this width.
  localparam int ACC_W  = 2 * dataWidth + $clog2(numWeight) + 1;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

  state_t                     state;
  logic [addressWidth-1:0]    count;
  logic signed [dataWidth-1:0] in_reg;
  logic                       in_reg_valid;
  logic signed [PROD_W-1:0]   prod;
  logic                       prod_valid;
  logic signed [ACC_W-1:0]    acc;
  logic                       accept;
  logic signed [CALC_W-1:0]   sum_wide;
  logic signed [dataWidth-1:0] result;

  assign in_ready  = (state == ACCUM);
  // Gating with rst_n keeps the memory quiet while reset is held.
  assign accept    = in_valid && in_ready && rst_n;
  assign w_rd_en   = accept;
  assign w_rd_addr = count;

  // Bias is aligned to the product's 2*fracWidth scale before the final shift.
  assign sum_wide = CALC_W'(acc) + (CALC_W'(bias) <<< fracWidth);
  assign result   = dataWidth'(shift_sat(sum_wide, fracWidth, dataWidth));

  // Two-stage datapath: capture the element, then multiply by the weight that
  // the memory returns one cycle after the read was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_reg       <= '0;
      in_reg_valid <= 1'b0;
      prod         <= '0;
      prod_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value from
      // before the edge, which is what turns these lines into a pipeline.
      in_reg_valid <= accept;
      if (accept) begin
        in_reg <= in_data;
      end
      prod_valid <= in_reg_valid;
      if (in_reg_valid) begin
        prod <= PROD_W'(in_reg) * PROD_W'(w_rd_data);
      end
    end
  end

  // Control FSM with the accumulator, element counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (prod_valid) begin
        acc <= acc + ACC_W'(prod);
      end
      case (state)
        ACCUM: begin
          if (accept) begin
            if (count == LAST_IDX) begin
              state <= DRAIN;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DRAIN: begin
          // No new elements enter here, so an empty pipeline means the last
          // product has already landed in the accumulator.
          if (!in_reg_valid && !prod_valid) begin
            out_valid <= 1'b1;
            out_data  <= result;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with a behavioural weight memory and a
// plain-arithmetic reference model of the neuron sum.
module tb_neuron_mac;

  localparam int NW = 3;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int FW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 w_rd_en;
  logic [AW-1:0]        w_rd_addr;
  logic signed [DW-1:0] w_rd_data;
  logic signed [DW-1:0] bias;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_ready;

  logic [DW-1:0] xs [NW];
  logic [DW-1:0] ws [NW];

  int total  = 0;
  int passed = 0;

  neuron_mac #(
    .numWeight   (NW),
    .addressWidth(AW),
    .dataWidth   (DW),
    .fracWidth   (FW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .w_rd_en  (w_rd_en),
    .w_rd_addr(w_rd_addr),
    .w_rd_data(w_rd_data),
    .bias     (bias),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Synchronous-read weight memory sitting next to the DUT.
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      w_rd_data <= (w_rd_addr < AW'(NW)) ? ws[w_rd_addr] : 16'h0000;
    end
  end

  // Reference: exact integer dot product plus bias in Q(2*FW), floor-divide
  // by 2**FW, clamp to the 16-bit signed range.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < NW; i++) begin
      s += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    end
    s += longint'($signed(b)) * 256;
    s = s >>> FW;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return DW'(s);
  endfunction

  // One full evaluation from the current xs/ws/bias. gap = idle cycles
  // between elements, hold = cycles out_ready stays low after out_valid,
  // early = out_ready already high before out_valid rises.
  task automatic run_eval(input string name, input int gap, input int hold, input bit early);
    logic [DW-1:0] exp_v;
    bit            addr_ok;
    bit            stable_ok;
    int            lat;
    exp_v   = model(bias);
    addr_ok = 1'b1;
    out_ready = early;
    for (int i = 0; i < NW; i++) begin
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = xs[i];
      #0;
      if (!(in_ready && w_rd_en && (w_rd_addr == AW'(i)))) addr_ok = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (addr_ok) passed++;
    else $display("FAIL %s addr_seq: read address sequence not 0..%0d with w_rd_en on each accept", name, NW - 1);
    total++;
    if (out_valid === 1'b1 && lat == 3) passed++;
    else $display("FAIL %s latency: out_valid=%b after %0d edges, required 1 after 3", name, out_valid, lat);
    total++;
    if (out_data === exp_v) passed++;
    else $display("FAIL %s out_data: got 0x%04h, required 0x%04h", name, out_data, exp_v);
    if (!early) begin
      stable_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (!(out_valid === 1'b1 && out_data === exp_v && in_ready === 1'b0)) stable_ok = 1'b0;
      end
      if (hold > 0) begin
        total++;
        if (stable_ok) passed++;
        else $display("FAIL %s hold: out_valid=%b out_data=0x%04h in_ready=%b, required 1/0x%04h/0", name, out_valid, out_data, in_ready, exp_v);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid === 1'b0 && in_ready === 1'b1) passed++;
    else $display("FAIL %s release: out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
  endtask

  task automatic test_reset();
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b0;
    bias      = '0;
    rst_n     = 1'b0;
    #12;
    total++;
    if (w_rd_en === 1'b0 && out_valid === 1'b0 && out_data === 16'h0000) passed++;
    else $display("FAIL reset_hold: w_rd_en=%b out_valid=%b out_data=0x%04h, required 0/0/0x0000", w_rd_en, out_valid, out_data);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready === 1'b1 && out_valid === 1'b0) passed++;
    else $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
  endtask

  task automatic test_basic();
    for (int i = 0; i < NW; i++) begin
      ws[i] = 16'h0100;
      xs[i] = 16'((i + 1) * 256);
    end
    bias = 16'h0080;
    total++;
    if (model(bias) === 16'h0680) passed++;
    else $display("FAIL basic_model: reference 0x%04h, required 0x0680", model(bias));
    run_eval("basic", 0, 0, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NW; i++) begin ws[i] = 16'h7FFF; xs[i] = 16'h7FFF; end
    bias = '0;
    run_eval("sat_pos", 0, 1, 1'b0);
    for (int i = 0; i < NW; i++) begin ws[i] = 16'h8000; xs[i] = 16'h7FFF; end
    run_eval("sat_neg", 0, 1, 1'b0);
  endtask

  task automatic test_bubbles();
    for (int i = 0; i < NW; i++) begin ws[i] = 16'hFF00; xs[i] = 16'h0100; end
    bias = '0;
    run_eval("bubbles", 1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NW; i++) begin
      ws[i] = 16'($urandom_range(0, 16'h03FF));
      xs[i] = 16'($urandom_range(0, 16'h03FF));
    end
    bias = 16'hFF80;
    run_eval("backpressure", 0, 5, 1'b0);
    for (int i = 0; i < NW; i++) begin
      ws[i] = 16'h0200 - 16'(i);
      xs[i] = 16'hFE00 + 16'(i * 3);
    end
    bias = 16'h0011;
    run_eval("after_release", 0, 0, 1'b0);
  endtask

  task automatic test_early_ready();
    for (int i = 0; i < NW; i++) begin ws[i] = 16'h0180; xs[i] = 16'hFF40; end
    bias = 16'h0003;
    run_eval("early_ready", 0, 0, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit quiet;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0500;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet && in_ready === 1'b1) passed++;
    else $display("FAIL mid_reset: out_valid seen=%b in_ready=%b, required no out_valid and in_ready 1", !quiet, in_ready);
    for (int i = 0; i < NW; i++) begin ws[i] = 16'h0040 * 16'(i + 1); xs[i] = 16'h0300; end
    bias = 16'h0100;
    run_eval("post_reset", 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NW; i++) begin
        if (r[0]) begin
          ws[i] = 16'($urandom);
          xs[i] = 16'($urandom);
        end else begin
          ws[i] = 16'($urandom_range(0, 16'h07FF)) - 16'h0400;
          xs[i] = 16'($urandom_range(0, 16'h07FF)) - 16'h0400;
        end
      end
      bias = 16'($urandom);
      run_eval($sformatf("random%0d", r), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    bias      = '0;
    for (int i = 0; i < NW; i++) begin ws[i] = '0; xs[i] = '0; end
    test_reset();
    test_basic();
    test_saturation();
    test_bubbles();
    test_backpressure();
    test_early_ready();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
